// File: rtl/simple_io_pkg.sv
// Shared opcode constants and I/O instruction decode for the simple I/O responder.
package simple_io_pkg;

  localparam logic [1:0] OP1_ALU          = 2'b11;
  localparam logic [3:0] OP3_IN           = 4'b1100;
  localparam logic [3:0] OP3_OUT          = 4'b1101;
  localparam logic [2:0] WB_PHASE_DEFAULT = 3'd4;

  typedef enum logic [1:0] {
    IO_NONE = 2'd0,
    IO_IN   = 2'd1,
    IO_OUT  = 2'd2
  } io_op_e;

  function automatic io_op_e decode_io(input logic [15:0] instr);
    io_op_e op;
    op = IO_NONE;
    if (instr[15:14] == OP1_ALU) begin
      if (instr[7:4] == OP3_IN)       op = IO_IN;
      else if (instr[7:4] == OP3_OUT) op = IO_OUT;
    end
    return op;
  endfunction

endpackage

// File: rtl/simple_io_fifo.sv
// Power-of-two output FIFO; push is refused when full and pop is ignored when empty.
module simple_io_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic          pop,
  output logic [15:0]   head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // full/empty come from the registered count, so a same-cycle pop never frees a slot for a push
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];
  assign w_push    = push & ~full;
  assign w_pop     = pop & ~empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; gating with reset keeps a reset cycle from writing a stray word.
  always_ff @(posedge clock) begin
    if (reset && w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/simple_io_responder.sv
// Core-facing I/O responder: holds one input word for IN, queues OUT words in a FIFO,
// and stalls the core at write-back until the requested I/O can complete.
module simple_io_responder
  import simple_io_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [2:0] WB_PHASE   = WB_PHASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  phase,
  input  logic [15:0] instruction,
  input  logic [15:0] out_data,
  input  logic [15:0] ext_in_data,
  input  logic        ext_in_strobe,
  output logic [15:0] in_data,
  output logic        in_valid,
  output logic        in_overrun,
  output logic [15:0] out_fifo_data,
  output logic        out_fifo_valid,
  input  logic        out_fifo_ready,
  output logic        stall
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a FIFO word transfers on any rising edge where out_fifo_valid & out_fifo_ready;
  // out_fifo_data is stable while valid is high and ready is low. The core side handshakes
  // through stall: an IN/OUT at WB_PHASE completes on the first edge with stall low.

  logic [15:0]   r_in_data;
  logic          r_in_valid;
  logic          r_in_overrun;
  io_op_e        w_op;
  logic          w_at_wb;
  logic          w_in_req;
  logic          w_out_req;
  logic          w_consume;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;

  assign w_op      = decode_io(instruction);
  assign w_at_wb   = (phase == WB_PHASE);
  assign w_in_req  = w_at_wb & (w_op == IO_IN);
  assign w_out_req = w_at_wb & (w_op == IO_OUT);
  assign w_consume = w_in_req & r_in_valid;

  assign stall = reset & ((w_in_req & ~r_in_valid) | (w_out_req & w_fifo_full));

  assign in_data        = r_in_data;
  assign in_valid       = r_in_valid;
  assign in_overrun     = r_in_overrun;
  assign out_fifo_valid = ~w_fifo_empty;

  // A new strobe always wins over a consume, so the fresh word stays valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_in_data    <= '0;
      r_in_valid   <= 1'b0;
      r_in_overrun <= 1'b0;
    end else if (ext_in_strobe) begin
      r_in_data  <= ext_in_data;
      r_in_valid <= 1'b1;
      if (r_in_valid && !w_consume) r_in_overrun <= 1'b1;
    end else if (w_consume) begin
      r_in_valid <= 1'b0;
    end
  end

  simple_io_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_out_req),
    .push_data (out_data),
    .pop       (out_fifo_ready),
    .head_data (out_fifo_data),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  a_count_empty: assert property (@(posedge clock) disable iff (!reset)
    (w_fifo_empty == (w_fifo_count == '0)) && (w_fifo_count <= CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_simple_io_responder.sv
// Directed bench for simple_io_responder: IN holding register, overrun, stall and FIFO ordering.
module tb_simple_io_responder;
  import simple_io_pkg::*;

  localparam logic [15:0] INSTR_IN  = 16'hC0C0;
  localparam logic [15:0] INSTR_OUT = 16'hC0D0;
  localparam logic [15:0] INSTR_NOP = 16'h0000;
  localparam logic [2:0]  WB        = 3'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  phase = 3'd0;
  logic [15:0] instruction = INSTR_NOP;
  logic [15:0] out_data = '0;
  logic [15:0] ext_in_data = '0;
  logic        ext_in_strobe = 1'b0;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_overrun;
  logic [15:0] out_fifo_data;
  logic        out_fifo_valid;
  logic        out_fifo_ready = 1'b0;
  logic        stall;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  simple_io_responder dut (
    .clock          (clock),
    .reset          (reset),
    .phase          (phase),
    .instruction    (instruction),
    .out_data       (out_data),
    .ext_in_data    (ext_in_data),
    .ext_in_strobe  (ext_in_strobe),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_overrun     (in_overrun),
    .out_fifo_data  (out_fifo_data),
    .out_fifo_valid (out_fifo_valid),
    .out_fifo_ready (out_fifo_ready),
    .stall          (stall)
  );

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_core();
    phase       = 3'd0;
    instruction = INSTR_NOP;
  endtask

  task automatic strobe(input logic [15:0] v);
    ext_in_data   = v;
    ext_in_strobe = 1'b1;
    tick();
    ext_in_strobe = 1'b0;
  endtask

  task automatic out_issue(input logic [15:0] v);
    phase       = WB;
    instruction = INSTR_OUT;
    out_data    = v;
    exp_q.push_back(v);
  endtask

  task automatic out_finish(input string name);
    int n;
    n = 0;
    @(negedge clock);
    while (stall && n < 50) begin
      n++;
      @(negedge clock);
    end
    check(name, 16'(stall), 16'h0);
    tick();
    idle_core();
  endtask

  task automatic do_out(input logic [15:0] v);
    out_issue(v);
    out_finish("out_push_stall_release");
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_fifo_ready = 1'b1;
    while (out_fifo_valid && n < 50) begin
      tick();
      n++;
    end
    out_fifo_ready = 1'b0;
    check(name, 16'(out_fifo_valid), 16'h0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (reset && out_fifo_valid && out_fifo_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_unexpected_pop: got %h expected no word", out_fifo_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_fifo_data !== e) begin
          n_fail++;
          $display("FAIL fifo_order: got %h expected %h", out_fifo_data, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset with an IN request pending: stall must stay low
    reset       = 1'b0;
    phase       = WB;
    instruction = INSTR_IN;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_stall",      16'(stall),          16'h0);
    check("rst_in_data",    in_data,             16'h0);
    check("rst_in_valid",   16'(in_valid),       16'h0);
    check("rst_in_overrun", 16'(in_overrun),     16'h0);
    check("rst_fifo_valid", 16'(out_fifo_valid), 16'h0);
    tick();
    reset = 1'b1;
    idle_core();

    // strobe then IN consume
    strobe(16'h00A5);
    @(negedge clock);
    check("in_load_valid", 16'(in_valid), 16'h1);
    check("in_load_data",  in_data,       16'h00A5);
    tick();
    phase = WB; instruction = INSTR_IN;
    @(negedge clock);
    check("in_ready_stall", 16'(stall), 16'h0);
    check("in_ready_data",  in_data,    16'h00A5);
    tick();
    idle_core();
    @(negedge clock);
    check("in_consumed", 16'(in_valid), 16'h0);
    tick();

    // IN waits for a word
    phase = WB; instruction = INSTR_IN;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("in_wait_stall", 16'(stall), 16'h1);
    end
    tick();
    ext_in_data = 16'h1234; ext_in_strobe = 1'b1;
    @(negedge clock);
    check("in_strobe_cycle_stall", 16'(stall), 16'h1);
    tick();
    ext_in_strobe = 1'b0;
    @(negedge clock);
    check("in_after_strobe_stall", 16'(stall), 16'h0);
    check("in_after_strobe_data",  in_data,    16'h1234);
    tick();
    idle_core();
    @(negedge clock);
    check("in_wait_consumed", 16'(in_valid), 16'h0);
    tick();

    // overrun, then strobe + consume in the same cycle
    strobe(16'h0011);
    strobe(16'h0022);
    @(negedge clock);
    check("ovr_data",    in_data,         16'h0022);
    check("ovr_flag",    16'(in_overrun), 16'h1);
    check("ovr_valid",   16'(in_valid),   16'h1);
    tick();
    ext_in_data = 16'h0033; ext_in_strobe = 1'b1;
    phase = WB; instruction = INSTR_IN;
    @(negedge clock);
    check("sc_stall", 16'(stall), 16'h0);
    tick();
    ext_in_strobe = 1'b0;
    idle_core();
    @(negedge clock);
    check("sc_valid",   16'(in_valid),   16'h1);
    check("sc_data",    in_data,         16'h0033);
    check("sc_overrun", 16'(in_overrun), 16'h1);
    tick();
    phase = WB; instruction = INSTR_IN;
    tick();
    idle_core();

    // fill FIFO, stall on 5th OUT, single pop, push lands next cycle
    for (int v = 1; v <= 4; v++) do_out(16'(v));
    out_issue(16'h0005);
    @(negedge clock);
    check("full_stall", 16'(stall), 16'h1);
    tick();
    out_fifo_ready = 1'b1;
    @(negedge clock);
    check("full_pop_no_push", 16'(stall), 16'h1);
    tick();
    out_fifo_ready = 1'b0;
    @(negedge clock);
    check("full_push_next", 16'(stall), 16'h0);
    tick();
    idle_core();
    drain("drain_full");

    // simultaneous push/pop at count 2, then wrap
    do_out(16'h000A);
    do_out(16'h000B);
    out_issue(16'h000C);
    out_fifo_ready = 1'b1;
    @(negedge clock);
    check("pp_stall", 16'(stall), 16'h0);
    tick();
    idle_core();
    out_fifo_ready = 1'b0;
    out_issue(16'h000D);
    @(negedge clock);
    check("pp_push3_stall", 16'(stall), 16'h0);
    tick();
    idle_core();
    out_issue(16'h000E);
    @(negedge clock);
    check("pp_push4_stall", 16'(stall), 16'h0);
    tick();
    idle_core();
    out_issue(16'h000F);
    @(negedge clock);
    check("pp_count_held", 16'(stall), 16'h1);
    tick();
    out_fifo_ready = 1'b1;
    out_finish("pp_push5_release");
    drain("drain_wrap");

    // pop request on an empty FIFO is ignored
    out_fifo_ready = 1'b1;
    tick();
    tick();
    out_fifo_ready = 1'b0;
    do_out(16'h0123);
    @(negedge clock);
    check("empty_pop_head", out_fifo_data, 16'h0123);
    tick();
    drain("drain_empty_pop");

    // reset mid-operation
    do_out(16'h0031);
    do_out(16'h0032);
    do_out(16'h0033);
    strobe(16'h0044);
    reset = 1'b0;
    phase = WB; instruction = INSTR_OUT; out_data = 16'h0099;
    @(negedge clock);
    check("mid_rst_stall", 16'(stall), 16'h0);
    tick();
    reset = 1'b1;
    idle_core();
    exp_q.delete();
    @(negedge clock);
    check("mid_rst_in_valid",   16'(in_valid),       16'h0);
    check("mid_rst_in_data",    in_data,             16'h0);
    check("mid_rst_overrun",    16'(in_overrun),     16'h0);
    check("mid_rst_fifo_valid", 16'(out_fifo_valid), 16'h0);
    tick();
    do_out(16'h0077);
    @(negedge clock);
    check("post_rst_head", out_fifo_data, 16'h0077);
    tick();
    drain("drain_post_rst");

    check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
